// File: rtl/tdm_demux4.sv
// tdm_demux4: receive-side deinterleaver for 4-slot TDM lanes.
// Restores polarity of samples from the inverting select cell, gathers one
// frame into shadow registers and publishes it on four lane registers with a
// one-cycle frame-valid strobe. Tracks frame lock and a sticky framing error.
module tdm_demux4 #(
   parameter int unsigned WIDTH  = 1,
   parameter bit          INVERT = 1'b1
) (
   input  logic             CK,
   input  logic             RST,
   input  logic [WIDTH-1:0] D,
   input  logic             DV,
   input  logic             SOF,
   input  logic             ERR_CLR,
   output logic [WIDTH-1:0] Z0,
   output logic [WIDTH-1:0] Z1,
   output logic [WIDTH-1:0] Z2,
   output logic [WIDTH-1:0] Z3,
   output logic             ZV,
   output logic [1:0]       SLOT,
   output logic             LOCK,
   output logic             ERR
);

   localparam logic [0:0] HUNT   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]       state;
   logic [1:0]       slot;
   logic [WIDTH-1:0] s0, s1, s2;
   logic [WIDTH-1:0] z0, z1, z2, z3;
   logic             zv;
   logic             err;

   logic [WIDTH-1:0] v;
   logic             x_seen;
   logic             err_event;

   // Sample polarity restore, unknown-control detection and error event decode.
   always_comb begin
      v         = INVERT ? ~D : D;
      x_seen    = (^{DV, SOF} === 1'bx);
      err_event = 1'b0;
      if (x_seen) begin
         err_event = 1'b1;
      end else if (DV && (state == LOCKED)) begin
         // Early SOF (slot 1..3) or missing SOF (slot 0) are framing errors.
         if (SOF && (slot != 2'd0))
            err_event = 1'b1;
         else if (!SOF && (slot == 2'd0))
            err_event = 1'b1;
      end
   end

   // Sticky error flag: a new error event wins over a clear on the same edge.
   always_ff @(posedge CK) begin
      if (RST)
         err <= 1'b0;
      else
         err <= err_event | (err & ~ERR_CLR);
   end

   // Framing FSM, shadow capture and lane publication.
   always_ff @(posedge CK) begin
      if (RST) begin
         state <= HUNT;
         slot  <= 2'd0;
         s0    <= '0;
         s1    <= '0;
         s2    <= '0;
         z0    <= '0;
         z1    <= '0;
         z2    <= '0;
         z3    <= '0;
         zv    <= 1'b0;
      end else begin
         zv <= 1'b0;
         if (x_seen) begin
            state <= HUNT;
            slot  <= 2'd0;
         end else if (DV) begin
            if (SOF) begin
               // Frame start in either state; an early SOF simply restarts the
               // frame, discarding the partial one.
               s0    <= v;
               slot  <= 2'd1;
               state <= LOCKED;
            end else if (state == LOCKED) begin
               case (slot)
                  2'd0: begin
                     state <= HUNT;
                     slot  <= 2'd0;
                  end
                  2'd1: begin
                     s1   <= v;
                     slot <= 2'd2;
                  end
                  2'd2: begin
                     s2   <= v;
                     slot <= 2'd3;
                  end
                  default: begin
                     z0   <= s0;
                     z1   <= s1;
                     z2   <= s2;
                     z3   <= v;
                     zv   <= 1'b1;
                     slot <= 2'd0;
                  end
               endcase
            end
         end
      end
   end

   assign Z0   = z0;
   assign Z1   = z1;
   assign Z2   = z2;
   assign Z3   = z3;
   assign ZV   = zv;
   assign SLOT = slot;
   assign LOCK = (state == LOCKED);
   assign ERR  = err;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: scoreboard bench for tdm_demux4 (WIDTH=4, INVERT=1).
// Directed scenarios followed by constrained-random traffic; a queue-based
// frame model pushes expected lane words, a negedge monitor pops on ZV.
module tb_tdm_demux4;

   localparam int unsigned W = 4;

   logic         ck = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] d = '0;
   logic         dv = 1'b0;
   logic         sof = 1'b0;
   logic         err_clr = 1'b0;
   logic [W-1:0] z0, z1, z2, z3;
   logic         zv;
   logic [1:0]   slot;
   logic         lock;
   logic         err;

   tdm_demux4 #(.WIDTH(W), .INVERT(1'b1)) dut (
      .CK(ck), .RST(rst), .D(d), .DV(dv), .SOF(sof), .ERR_CLR(err_clr),
      .Z0(z0), .Z1(z1), .Z2(z2), .Z3(z3), .ZV(zv),
      .SLOT(slot), .LOCK(lock), .ERR(err)
   );

   always #5 ck = ~ck;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   // Reference model state: collected samples of the current frame.
   logic [W-1:0]  frame[$];
   bit            m_locked = 1'b0;
   bit            m_err = 1'b0;
   logic [4*W-1:0] exp_q[$];
   bit            mon_en = 1'b0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   function automatic void model(bit r, bit v_dv, bit v_sof, logic [W-1:0] v_d, bit clr);
      bit ev;
      logic [W-1:0] v;
      if (r) begin
         frame.delete();
         m_locked = 1'b0;
         m_err = 1'b0;
         return;
      end
      ev = 1'b0;
      v = ~v_d;
      if (v_dv) begin
         if (v_sof) begin
            if (m_locked && frame.size() != 0) ev = 1'b1;
            frame.delete();
            frame.push_back(v);
            m_locked = 1'b1;
         end else if (m_locked) begin
            if (frame.size() == 0) begin
               ev = 1'b1;
               m_locked = 1'b0;
            end else begin
               frame.push_back(v);
               if (frame.size() == 4) begin
                  exp_q.push_back({frame[0], frame[1], frame[2], frame[3]});
                  frame.delete();
               end
            end
         end
      end
      m_err = ev | (m_err & ~clr);
   endfunction

   task automatic cycle(bit r, bit v_dv, bit v_sof, logic [W-1:0] v_d, bit clr);
      @(negedge ck);
      rst = r; dv = v_dv; sof = v_sof; d = v_d; err_clr = clr;
      @(posedge ck);
      model(r, v_dv, v_sof, v_d, clr);
      mon_en = 1'b1;
   endtask

   task automatic send_frame(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c, logic [W-1:0] e, bit gaps);
      logic [W-1:0] s[4];
      s[0] = a; s[1] = b; s[2] = c; s[3] = e;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, (i == 0), s[i], 1'b0);
         if (gaps) cycle(1'b0, 1'b0, 1'b0, 4'hA, 1'b0);
      end
   endtask

   // Monitor: pop the scoreboard whenever ZV is presented; track status outputs.
   initial begin
      logic [4*W-1:0] e;
      forever begin
         @(negedge ck);
         if (mon_en) begin
            if (zv === 1'b1) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_zv", 32'(zv), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("frame_lanes", 32'({z0, z1, z2, z3}), 32'(e));
               end
            end
            chk("slot", 32'(slot), m_locked ? 32'(frame.size()) : 32'd0);
            chk("lock", 32'(lock), 32'(m_locked));
            chk("err", 32'(err), 32'(m_err));
         end
      end
   end

   initial begin
      bit r, v_dv, v_sof, clr;
      // Reset with DV asserted for two cycles.
      cycle(1'b1, 1'b1, 1'b1, 4'h5, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 4'h6, 1'b0);
      @(negedge ck);
      chk("reset_lanes", 32'({z0, z1, z2, z3}), 32'd0);
      chk("reset_zv", 32'(zv), 32'd0);

      // Basic frame, then back-to-back frames.
      send_frame(4'h0, 4'h1, 4'h1, 4'h0, 1'b0);
      send_frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
      send_frame(4'h5, 4'h6, 4'h7, 4'h8, 1'b0);
      // DV gaps.
      send_frame(4'h9, 4'hB, 4'hC, 4'hD, 1'b1);
      // Early SOF at slot 2, then a clean frame.
      cycle(1'b0, 1'b1, 1'b1, 4'h3, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 4'h4, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 4'h7, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 4'h8, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 4'h9, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 4'hE, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      // Missing SOF after a completed frame, with clear on the same edge.
      cycle(1'b0, 1'b1, 1'b0, 4'h2, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 4'h2, 1'b0);
      send_frame(4'hF, 4'h0, 4'h5, 4'hA, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      // Reset mid-frame, then a clean frame.
      cycle(1'b0, 1'b1, 1'b1, 4'h1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 4'h2, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 4'h3, 1'b0);
      @(negedge ck);
      chk("midreset_lanes", 32'({z0, z1, z2, z3}), 32'd0);
      send_frame(4'h6, 4'h9, 4'hC, 4'h3, 1'b0);

      // Constrained-random traffic, mostly well-framed.
      for (int i = 0; i < 2000; i++) begin
         r     = ($urandom_range(0, 199) == 0);
         v_dv  = ($urandom_range(0, 3) != 0);
         v_sof = (m_locked ? (frame.size() == 0) : ($urandom_range(0, 2) == 0));
         if ($urandom_range(0, 19) == 0) v_sof = ~v_sof;
         clr   = ($urandom_range(0, 9) == 0);
         cycle(r, v_dv, v_sof, 4'($urandom), clr);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      @(negedge ck);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the inverting 4:1 select cell used on our time-multiplexed lanes.
- Takes one serial sample stream, 4 slots per frame, from an inverting mux path and restores polarity.
- Deinterleaves each frame onto four parallel lane registers and pulses a frame-valid strobe.
- Provides frame lock and a sticky framing-error flag for the fault-injection benches.

Parameters:
- WIDTH, 1, bit width of each sample and of each lane output.
- INVERT, 1. When 1, stored value = ~D, undoing the inversion in the transmit cell. When 0, stored value = D.

Ports:
- CK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- D  in  WIDTH  received sample.
- DV  in  1  D is valid this cycle.
- SOF  in  1  marks the slot-0 sample of a frame; meaningful only when DV=1.
- ERR_CLR  in  1  clears ERR.
- Z0  out  WIDTH  lane 0 output, registered.
- Z1  out  WIDTH  lane 1 output, registered.
- Z2  out  WIDTH  lane 2 output, registered.
- Z3  out  WIDTH  lane 3 output, registered.
- ZV  out  1  one-cycle strobe: Z0..Z3 hold a new complete frame.
- SLOT  out  2  next expected slot index.
- LOCK  out  1  1 when the FSM is in LOCKED.
- ERR  out  1  sticky framing error.

Behaviour:
- Reset, when RST=1 at an edge:
  - Z0..Z3=0, ZV=0, SLOT=0, LOCK=0, ERR=0.
  - Shadow regs S0..S2=0; FSM goes to HUNT.
  - RST overrides every other input, including mid-frame; any partial frame is discarded.
- Sample value: v = INVERT ? ~D : D.
- Cycles with DV=0: no state change, except ZV<=0 and ERR_CLR handling.
- HUNT state:
  - DV=1, SOF=0: sample dropped; no error.
  - DV=1, SOF=1: S0<=v, SLOT<=1, go to LOCKED.
- LOCKED state, DV=1, SOF=0:
  - SLOT=1: S1<=v, SLOT<=2.
  - SLOT=2: S2<=v, SLOT<=3.
  - SLOT=3: on the same edge Z0<=S0, Z1<=S1, Z2<=S2, Z3<=v; ZV<=1; SLOT<=0.
  - SLOT=0 (missing SOF): ERR<=1, sample dropped, SLOT<=0, go to HUNT.
- LOCKED state, DV=1, SOF=1:
  - SLOT=0: normal frame start, S0<=v, SLOT<=1.
  - SLOT=1..3 (early SOF): ERR<=1, partial frame discarded, S0<=v, SLOT<=1, stay LOCKED. Z0..Z3 unchanged, no ZV.
- Latency: ZV and the new Z0..Z3 are visible together in the cycle after the edge that accepts the slot-3 sample.
- ZV is high for exactly one cycle per completed frame.
- Back-to-back frames (DV=1 every cycle) produce ZV every 4th cycle.
- Z0..Z3 hold their values until the next complete frame.
- ERR:
  - ERR_CLR=1 clears ERR.
  - If an error event and ERR_CLR occur on the same edge, set wins and ERR=1.
  - ERR does not affect data flow.
- SLOT wraps 3->0 only through frame completion; no other wrap path exists.
- LOCK = (state==LOCKED).
- Any X on DV or SOF while RST=0 drives the FSM to HUNT and sets ERR.

Test Plan:
- Reset: RST=1 for 2 cycles with DV=1 -> Z0..Z3=0, ZV=0, SLOT=0, LOCK=0, ERR=0.
- Basic frame, WIDTH=1, INVERT=1: D=0,1,1,0 with SOF on the first sample, DV continuous -> next cycle Z0=1, Z1=0, Z2=0, Z3=1, ZV=1 for 1 cycle, SLOT=0, LOCK=1.
- Back-to-back frames, WIDTH=4, INVERT=0: D=1,2,3,4 then 5,6,7,8 -> ZV pulses at cycles 5 and 9; Z0..Z3 = 1,2,3,4 then 5,6,7,8.
- DV gaps: same frame with DV low every other cycle -> identical Z values; exactly one ZV.
- Early SOF: SOF at slot 2 of a frame -> ERR=1, no ZV, Z unchanged; the following clean frame completes normally.
- Missing SOF: after a completed frame, DV=1 with SOF=0 -> ERR=1, LOCK=0; the next SOF relocks. ERR_CLR and an error event on the same edge -> ERR stays 1.
- Reset mid-frame: RST=1 after 2 samples -> all outputs return to reset values; the next frame completes normally.
